// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder controller. It loads two operands and a
//   carry-in on start, then drives one bit pair per clock, LSB first, into
//   an external 1-bit full-adder cell. Alongside each bit pair it drives
//   the carry registered from the previous bit. The sum bits returned by
//   the cell are collected in a shift register. When all WIDTH bits have
//   been processed, the WIDTH-bit sum and the final carry-out are latched
//   and held until the next completion.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   start               operation request, sampled only while idle
//   a_in, b_in, ci_in   operands and initial carry, sampled with start
//   fa_a, fa_b, fa_ci   bit pair and carry presented to the full-adder cell
//   fa_s, fa_co         sum and carry returned by the cell (combinational)
//   busy                high while an operation is in flight (RUN, DONE)
//   done                one-cycle completion pulse
//   sum, co             last completed result
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; cell inputs held at 0
// RUN   | one bit per cycle through the cell, cnt counts bits done
// DONE  | result latched; done pulse for this single cycle
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      co_q     <= co_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    co_d     = co_q;
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_ci    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = ci_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        fa_a     = a_sh_q[0];
        fa_b     = b_sh_q[0];
        fa_ci    = carry_q;
        // The sum bit enters at the MSB, so after WIDTH shifts the first
        // (LSB) result bit has reached position 0.
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          co_d    = fa_co;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         ci_in;
  logic         fa_a, fa_b, fa_ci, fa_s, fa_co;
  logic         busy, done, co;
  logic [W-1:0] sum;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
    .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
    .fa_s(fa_s), .fa_co(fa_co),
    .busy(busy), .done(done), .sum(sum), .co(co)
  );

  // reference full-adder cell
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           due;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] last_s = '0;
  logic         last_c = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("co", 32'(co), 32'(e.c));
        chk("done_latency", 32'(cyc), 32'(e.due));
        last_s = e.s;
        last_c = e.c;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  // issue one operation from idle; returns at the negedge of the first RUN cycle
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] es, input logic ec);
    exp_t e;
    wait_idle();
    chk("sum_held", 32'(sum), 32'(last_s));
    chk("co_held", 32'(co), 32'(last_c));
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    ci_in = ci;
    @(posedge clk);
    #1;
    e.s   = es;
    e.c   = ec;
    e.due = cyc + W;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    ci_in = $urandom_range(0, 1);
  endtask

  initial begin
    int bc;
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rc;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; ci_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_co", 32'(co), 32'(0));
    chk("rst_fa", 32'({fa_a, fa_b, fa_ci}), 32'(0));
    rst = 1'b0;

    // basic op with busy-length check
    do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bc), 32'(9));

    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // start re-pulsed during RUN cycle 3 must be ignored
    do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a_in = 8'h11; b_in = 8'h22; ci_in = 1'b0;
    @(negedge clk);
    start = 1'b0;

    // reset during RUN cycle 4
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_sum", 32'(sum), 32'(0));
    chk("mid_rst_co", 32'(co), 32'(0));
    chk("mid_rst_fa", 32'({fa_a, fa_b, fa_ci}), 32'(0));
    last_s = '0;
    last_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h10, 8'h20, 1'b1, 8'h31, 1'b0);

    // start held high: one acceptance every W+2 cycles, operands ignored in between
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      if (i % 2 == 0) begin
        a_in = 8'h35; b_in = 8'h4A; ci_in = 1'b0; e.s = 8'h7F; e.c = 1'b0;
      end else begin
        a_in = 8'hFF; b_in = 8'h01; ci_in = 1'b0; e.s = 8'h00; e.c = 1'b1;
      end
      @(posedge clk);
      #1;
      e.due = cyc + W;
      sb.push_back(e);
      repeat (W + 1) begin
        @(negedge clk);
        a_in = $urandom; b_in = $urandom; ci_in = $urandom_range(0, 1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    last_s = 8'h00;
    last_c = 1'b1;

    // random operations against an arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom_range(0, 1);
      r  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, r[W-1:0], r[W]);
    end

    bc = 0;
    while (sb.size() != 0 && bc < 50) begin
      @(negedge clk);
      bc++;
    end
    chk("sb_drain", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
